// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: two-requester round-robin arbiter and transaction sequencer
// in front of a single SPI byte engine. Owns chip-select for the whole
// multi-byte transaction, inserts CS setup/hold gaps, issues one engine byte
// at a time and routes each received byte back to the owning requester only.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN (idle-owner watchdog in WAIT_TX).
//
// Parameters
//   CS_SETUP_CYC  CS assertion to first byte offered (SETUP lasts this + 1)
//   CS_HOLD_CYC   last byte done to CS release (HOLD lasts this + 1)
//   TIMEOUT_CYC   WAIT_TX watchdog limit (only with SPI_ARB_TIMEOUT_EN)
// Ports
//   clk, nrst              clock, async active-low reset
//   req[1:0]               per-requester transaction request
//   gnt[1:0]               one-hot grant, CS assertion through end of HOLD
//   tx_valid/tx_data/tx_last/tx_ready  per-requester byte handshake
//   rx_valid[1:0], rx_data returned byte, pulsed to the owner only
//   eng_start, eng_tx      byte launch to the engine
//   eng_done, eng_rx       byte completion from the engine
//   spi_cs_n               chip select, active-low
//   timeout_err            watchdog abort pulse (tied 0 without the macro)

module spi_bus_arbiter #(
    parameter logic [7:0]  CS_SETUP_CYC = 8'd2,
    parameter logic [7:0]  CS_HOLD_CYC  = 8'd2,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd1024
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  tx_valid,
    input  logic [15:0] tx_data,
    input  logic [1:0]  tx_last,
    output logic [1:0]  tx_ready,
    output logic [1:0]  rx_valid,
    output logic [7:0]  rx_data,
    output logic        eng_start,
    output logic [7:0]  eng_tx,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx,
    output logic        spi_cs_n,
    output logic        timeout_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WD_W   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_WAIT_TX = 3'd2;
    localparam logic [2:0] ST_BUSY    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              owner_q,     owner_d;
    logic [1:0]        gnt_q,       gnt_d;
    logic              cs_n_q,      cs_n_d;
    logic              rr_last_q,   rr_last_d;
    logic              last_flag_q, last_flag_d;
    logic [BYTE_W-1:0] eng_tx_q,    eng_tx_d;
    logic              eng_start_q, eng_start_d;
    logic [1:0]        rx_valid_q,  rx_valid_d;
    logic [BYTE_W-1:0] rx_data_q,   rx_data_d;

    logic              winner_c;
    logic [BYTE_W-1:0] owner_tx_c;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_err_q, timeout_err_d;
`else
    logic [WD_W-1:0]   unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Sole requester wins; on a tie the one not served last wins.
    assign winner_c   = (req == 2'b11) ? ~rr_last_q : req[1];
    assign owner_tx_c = owner_q ? tx_data[15:8] : tx_data[7:0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        rr_last_d   = rr_last_q;
        last_flag_d = last_flag_q;
        eng_tx_d    = eng_tx_q;
        eng_start_d = 1'b0;
        rx_valid_d  = 2'b00;
        rx_data_d   = rx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d          = WD_W'(0);
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = winner_c;
                    gnt_d   = winner_c ? 2'b10 : 2'b01;
                    cs_n_d  = 1'b0;
                    cnt_d   = CS_SETUP_CYC;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = ST_WAIT_TX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_TX: begin
                if (tx_valid[owner_q]) begin
                    eng_tx_d    = owner_tx_c;
                    eng_start_d = 1'b1;
                    last_flag_d = tx_last[owner_q];
                    state_d     = ST_BUSY;
                end else if (!req[owner_q]) begin
                    // Owner gave up mid-transaction: release CS normally.
                    cnt_d   = CS_HOLD_CYC;
                    state_d = ST_HOLD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wd_q == TIMEOUT_CYC - WD_W'(1)) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = CS_HOLD_CYC;
                    state_d       = ST_HOLD;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            ST_BUSY: begin
                if (eng_done) begin
                    rx_data_d  = eng_rx;
                    rx_valid_d = gnt_q;
                    if (last_flag_q) begin
                        cnt_d   = CS_HOLD_CYC;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT_TX;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(0)) begin
                    cs_n_d    = 1'b1;
                    gnt_d     = 2'b00;
                    rr_last_d = owner_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases CS and drops grants at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_W'(0);
            owner_q     <= 1'b0;
            gnt_q       <= 2'b00;
            cs_n_q      <= 1'b1;
            rr_last_q   <= 1'b1;
            last_flag_q <= 1'b0;
            eng_tx_q    <= BYTE_W'(0);
            eng_start_q <= 1'b0;
            rx_valid_q  <= 2'b00;
            rx_data_q   <= BYTE_W'(0);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            rr_last_q   <= rr_last_d;
            last_flag_q <= last_flag_d;
            eng_tx_q    <= eng_tx_d;
            eng_start_q <= eng_start_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog counter and abort pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_q          <= WD_W'(0);
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign spi_cs_n  = cs_n_q;
    assign eng_tx    = eng_tx_q;
    assign eng_start = eng_start_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    // Byte acceptance is combinational so a waiting requester hands off immediately.
    assign tx_ready  = (state_q == ST_WAIT_TX) ? gnt_q : 2'b00;

endmodule
